// File: rtl/chk_pkg.sv
// Shared types and default widths for the q_mismatch_checker block.
package chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_CNT_W = 16;
  localparam int DEF_TS_W  = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/q_mismatch_checker.sv
// Compares a golden and a DUT bit stream over a start/stop run and keeps
// sample/error statistics. Optional last_err_cycle output: CHK_LAST_ERR_EN.
module q_mismatch_checker
  import chk_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TS_W        = DEF_TS_W,
  parameter int MAX_SAMPLES = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             valid,
  input  logic             q_ref,
  input  logic             q_dut,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] samples,
  output logic [CNT_W-1:0] errors,
  output logic             first_err_valid,
  output logic [TS_W-1:0]  first_err_cycle,
`ifdef CHK_LAST_ERR_EN
  output logic [TS_W-1:0]  last_err_cycle,
`endif
  output logic [1:0]       dbg_state
);

  localparam logic [CNT_W:0] MAX_EXT = (CNT_W + 1)'(MAX_SAMPLES);

  state_t          state_d, state_q;
  logic            busy_d, busy_q;
  logic            done_d, done_q;
  logic            fev_d, fev_q;
  logic [TS_W-1:0] fec_d, fec_q;
  logic [TS_W-1:0] cycle;
  logic            cnt_en, sample_inc, mismatch, auto_hit;

  // A start in RUN restarts, so the sample of that cycle is dropped.
  assign cnt_en     = (state_q == RUN) && !start;
  assign sample_inc = cnt_en && valid;
  assign mismatch   = sample_inc && (q_ref != q_dut);
  assign auto_hit   = (MAX_SAMPLES != 0) && sample_inc &&
                      (({1'b0, samples} + (CNT_W + 1)'(1)) == MAX_EXT);

  sat_counter #(.W(CNT_W)) u_samples (
    .clk(clk), .reset(reset), .clr(start), .inc(sample_inc), .cnt(samples)
  );

  sat_counter #(.W(CNT_W)) u_errors (
    .clk(clk), .reset(reset), .clr(start), .inc(mismatch), .cnt(errors)
  );

  sat_counter #(.W(TS_W)) u_cycle (
    .clk(clk), .reset(reset), .clr(start), .inc(cnt_en), .cnt(cycle)
  );

  always_comb begin
    state_d = state_q;
    fev_d   = fev_q;
    fec_d   = fec_q;
    if (start) begin
      state_d = RUN;
      fev_d   = 1'b0;
      fec_d   = '0;
    end else begin
      if ((state_q == RUN) && (stop || auto_hit)) begin
        state_d = DONE;
      end
      if (mismatch && !fev_q) begin
        fev_d = 1'b1;
        fec_d = cycle;
      end
    end
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fev_q   <= 1'b0;
      fec_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fev_q   <= fev_d;
      fec_q   <= fec_d;
    end
  end

`ifdef CHK_LAST_ERR_EN
  logic [TS_W-1:0] lec_d, lec_q;

  always_comb begin
    lec_d = lec_q;
    if (start) begin
      lec_d = '0;
    end else if (mismatch) begin
      lec_d = cycle;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lec_q <= '0;
    end else begin
      lec_q <= lec_d;
    end
  end

  assign last_err_cycle = lec_q;
`endif

  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = done_q && (errors == '0);
  assign first_err_valid = fev_q;
  assign first_err_cycle = fec_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_q_mismatch_checker.sv
// Directed bench for q_mismatch_checker: default, auto-stop and narrow-counter builds.
module tb_q_mismatch_checker;

  logic clk = 1'b0;
  logic reset, start, stop, valid, q_ref, q_dut;

  // Default build
  logic        busy, done, pass, fev;
  logic [15:0] samples, errors, fec;
  logic [1:0]  st;
`ifdef CHK_LAST_ERR_EN
  logic [15:0] lec;
`endif

  // MAX_SAMPLES = 5 build
  logic        m_busy, m_done, m_pass, m_fev;
  logic [15:0] m_samples, m_errors, m_fec;
  logic [1:0]  m_st;
`ifdef CHK_LAST_ERR_EN
  logic [15:0] m_lec;
`endif

  // CNT_W = 3 build
  logic        s_busy, s_done, s_pass, s_fev;
  logic [2:0]  s_samples, s_errors;
  logic [15:0] s_fec;
  logic [1:0]  s_st;
`ifdef CHK_LAST_ERR_EN
  logic [15:0] s_lec;
`endif

  int chk_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  q_mismatch_checker u_dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .valid(valid),
    .q_ref(q_ref), .q_dut(q_dut), .busy(busy), .done(done), .pass(pass),
    .samples(samples), .errors(errors), .first_err_valid(fev),
    .first_err_cycle(fec),
`ifdef CHK_LAST_ERR_EN
    .last_err_cycle(lec),
`endif
    .dbg_state(st)
  );

  q_mismatch_checker #(.MAX_SAMPLES(5)) u_dut_max (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .valid(valid),
    .q_ref(q_ref), .q_dut(q_dut), .busy(m_busy), .done(m_done), .pass(m_pass),
    .samples(m_samples), .errors(m_errors), .first_err_valid(m_fev),
    .first_err_cycle(m_fec),
`ifdef CHK_LAST_ERR_EN
    .last_err_cycle(m_lec),
`endif
    .dbg_state(m_st)
  );

  q_mismatch_checker #(.CNT_W(3)) u_dut_small (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .valid(valid),
    .q_ref(q_ref), .q_dut(q_dut), .busy(s_busy), .done(s_done), .pass(s_pass),
    .samples(s_samples), .errors(s_errors), .first_err_valid(s_fev),
    .first_err_cycle(s_fec),
`ifdef CHK_LAST_ERR_EN
    .last_err_cycle(s_lec),
`endif
    .dbg_state(s_st)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0;
    valid = 1'b0; q_ref = 1'b0; q_dut = 1'b0;
    tick();
    tick();

    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_pass", 32'(pass), 0);
    check("rst_samples", 32'(samples), 0);
    check("rst_errors", 32'(errors), 0);
    check("rst_fev", 32'(fev), 0);
    check("rst_fec", 32'(fec), 0);
    check("rst_state", 32'(st), 0);
    reset = 1'b0;
    tick();

    // 16 matching samples then stop
    pulse_start();
    check("s1_busy", 32'(busy), 1);
    for (int i = 0; i < 16; i++) begin
      valid = 1'b1;
      q_ref = 1'($urandom_range(0, 1));
      q_dut = q_ref;
      tick();
    end
    valid = 1'b0;
    stop  = 1'b1;
    tick();
    stop  = 1'b0;
    check("s1_done", 32'(done), 1);
    check("s1_busy_off", 32'(busy), 0);
    check("s1_pass", 32'(pass), 1);
    check("s1_samples", 32'(samples), 16);
    check("s1_errors", 32'(errors), 0);
    check("s1_fev", 32'(fev), 0);

    // Mismatches at run cycles 3 and 7, stop at cycle 9 with a counted sample
    pulse_start();
    for (int c = 0; c < 10; c++) begin
      valid = 1'b1;
      q_ref = 1'($urandom_range(0, 1));
      q_dut = q_ref ^ ((c == 3) || (c == 7));
      stop  = (c == 9);
      tick();
    end
    stop = 1'b0;
    check("s2_done", 32'(done), 1);
    check("s2_errors", 32'(errors), 2);
    check("s2_samples", 32'(samples), 10);
    check("s2_fev", 32'(fev), 1);
    check("s2_fec", 32'(fec), 3);
    check("s2_pass", 32'(pass), 0);
`ifdef CHK_LAST_ERR_EN
    check("s2_lec", 32'(lec), 7);
`endif
    // Samples and stop are ignored in DONE
    q_ref = 1'b1; q_dut = 1'b0; stop = 1'b1;
    tick();
    tick();
    stop = 1'b0; valid = 1'b0;
    check("s2_hold_samples", 32'(samples), 10);
    check("s2_hold_errors", 32'(errors), 2);
    check("s2_hold_done", 32'(done), 1);

    // Auto-stop at 5 samples with valid on every other cycle
    pulse_start();
    for (int c = 0; c < 9; c++) begin
      valid = (c % 2 == 0);
      q_ref = 1'b0; q_dut = 1'b0;
      tick();
      if (c == 7) begin
        check("s3_busy_pre", 32'(m_busy), 1);
        check("s3_samples_pre", 32'(m_samples), 4);
      end
    end
    check("s3_done", 32'(m_done), 1);
    check("s3_busy", 32'(m_busy), 0);
    check("s3_samples", 32'(m_samples), 5);
    valid = 1'b1;
    tick();
    tick();
    valid = 1'b0;
    check("s3_hold_samples", 32'(m_samples), 5);

    // Narrow counters saturate at 7
    pulse_start();
    for (int c = 0; c < 10; c++) begin
      valid = 1'b1; q_ref = 1'b1; q_dut = 1'b0;
      tick();
    end
    valid = 1'b0;
    stop  = 1'b1;
    tick();
    stop  = 1'b0;
    check("s4_errors", 32'(s_errors), 7);
    check("s4_samples", 32'(s_samples), 7);
    check("s4_fec", 32'(s_fec), 0);
    check("s4_done", 32'(s_done), 1);

    // start+stop together mid-run: restart wins
    pulse_start();
    for (int c = 0; c < 3; c++) begin
      valid = 1'b1; q_ref = 1'b0; q_dut = 1'b1;
      tick();
    end
    check("s5_errors_pre", 32'(errors), 3);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0; valid = 1'b0;
    check("s5_samples", 32'(samples), 0);
    check("s5_errors", 32'(errors), 0);
    check("s5_fev", 32'(fev), 0);
    check("s5_busy", 32'(busy), 1);
    check("s5_done", 32'(done), 0);
    tick();
    check("s5_busy_hold", 32'(busy), 1);

    // Reset mid-run after 4 errors, then a stray stop
    for (int c = 0; c < 4; c++) begin
      valid = 1'b1; q_ref = 1'b1; q_dut = 1'b0;
      tick();
    end
    valid = 1'b0;
    check("s6_errors_pre", 32'(errors), 4);
    check("s6_fec_pre", 32'(fec), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("s6_busy", 32'(busy), 0);
    check("s6_done", 32'(done), 0);
    check("s6_samples", 32'(samples), 0);
    check("s6_errors", 32'(errors), 0);
    check("s6_fev", 32'(fev), 0);
    check("s6_fec", 32'(fec), 0);
    check("s6_state", 32'(st), 0);
`ifdef CHK_LAST_ERR_EN
    check("s6_lec", 32'(lec), 0);
`endif
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    check("s6_stop_done", 32'(done), 0);
    check("s6_stop_state", 32'(st), 0);

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
